// File: rtl/tabla1_pkg.sv
// Shared truth-table constants and result type for the tabla1 lookup block.
package tabla1_pkg;

   localparam int unsigned IDX_W = 4;
   localparam int unsigned COV_W = 16;

   // Bit i of each constant is the table output for minterm i ({a,b,c} or {a,b,c,d}).
   localparam logic [7:0]       TABLA1A_TT = 8'b0011_0001;
   localparam logic [7:0]       TABLA1B_TT = 8'b1100_0111;
   localparam logic [COV_W-1:0] TABLA1C_TT = 16'b1011_0001_1011_1101;

   typedef struct packed {
      logic y1;
      logic y2;
      logic y3;
   } tabla1_res_t;

endpackage

// File: rtl/tabla1_lut.sv
// Purely combinational 4-input lookup of tables 1a, 1b and 1c.
module tabla1_lut
   import tabla1_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   output tabla1_res_t      res_c
);

   // Tables 1a/1b use only {a,b,c}; d is the LSB of the index and is dropped.
   always_comb begin
      res_c    = '0;
      res_c.y1 = TABLA1A_TT[idx_i[3:1]];
      res_c.y2 = TABLA1B_TT[idx_i[3:1]];
      res_c.y3 = TABLA1C_TT[idx_i];
   end

endmodule

// File: rtl/tabla1.sv
// Registered truth-table evaluator with a sticky coverage bitmap of sampled inputs.
module tabla1
   import tabla1_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   output logic             y1,
   output logic             y2,
   output logic             y3,
   output logic             valid,
   output logic [COV_W-1:0] seen,
   output logic             all_seen
);

   logic [IDX_W-1:0] idx;
   tabla1_res_t      lut_res;
   tabla1_res_t      res_q, res_d;
   logic             valid_q, valid_d;
   logic [COV_W-1:0] seen_q, seen_d;

   assign idx = {a, b, c, d};

   tabla1_lut u_lut (
      .idx_i (idx),
      .res_c (lut_res)
   );

   always_comb begin
      res_d   = res_q;
      valid_d = 1'b0;
      seen_d  = seen_q;
      if (en) begin
         res_d   = lut_res;
         valid_d = 1'b1;
         seen_d  = seen_q | (COV_W'(1) << idx);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q   <= '0;
         valid_q <= 1'b0;
         seen_q  <= '0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
         seen_q  <= seen_d;
      end
   end

   assign y1       = res_q.y1;
   assign y2       = res_q.y2;
   assign y3       = res_q.y3;
   assign valid    = valid_q;
   assign seen     = seen_q;
   assign all_seen = (seen_q == {COV_W{1'b1}});

endmodule

// File: tb/tb_tabla1.sv
// Directed and random checks of tabla1 against hand-derived truth tables.
module tb_tabla1;

   logic        clk = 1'b0;
   logic        rst_n, en, a, b, c, d;
   logic        y1, y2, y3, valid, all_seen;
   logic [15:0] seen;

   int tests_run = 0;
   int tests_failed = 0;

   tabla1 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3),
      .valid    (valid),
      .seen     (seen),
      .all_seen (all_seen)
   );

   always #5 clk = ~clk;

   // Reference tables written from the minterm lists, independent of the RTL constants.
   function automatic logic [2:0] ref_tab(input logic [3:0] m);
      logic [2:0] abc;
      abc = m[3:1];
      ref_tab[2] = abc inside {3'd0, 3'd4, 3'd5};
      ref_tab[1] = abc inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
      ref_tab[0] = m inside {4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd12, 4'd13, 4'd15};
   endfunction

   // Apply one input vector across one rising edge; outputs are sampled 1 time unit later.
   task automatic step(input logic r, input logic e, input logic [3:0] v);
      rst_n = r;
      en    = e;
      {a, b, c, d} = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      tests_run++;
      if ({y1, y2, y3, valid, seen, all_seen} !== 21'd0) begin
         tests_failed++;
         $display("FAIL reset: y=%b%b%b valid=%b seen=%h all_seen=%b, want all 0",
                  y1, y2, y3, valid, seen, all_seen);
      end
   endtask

   task automatic test_sweep3();
      bit exp_y1 [8] = '{1, 0, 0, 0, 1, 1, 0, 0};
      bit exp_y2 [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, {3'(i), 1'b0});
         tests_run++;
         if ({y1, y2, valid} !== {exp_y1[i], exp_y2[i], 1'b1}) begin
            tests_failed++;
            $display("FAIL sweep3[%0d]: y1=%b y2=%b valid=%b, want %b %b 1",
                     i, y1, y2, valid, exp_y1[i], exp_y2[i]);
         end
      end
   endtask

   task automatic test_sweep4();
      bit exp_y3 [16] = '{1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1};
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b1, 4'(i));
         tests_run++;
         if (y3 !== exp_y3[i] || all_seen !== (i == 15)) begin
            tests_failed++;
            $display("FAIL sweep4[%0d]: y3=%b all_seen=%b, want %b %b",
                     i, y3, all_seen, exp_y3[i], (i == 15));
         end
      end
      tests_run++;
      if (seen !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL sweep4_seen: seen=%h, want ffff", seen);
      end
   endtask

   task automatic test_hold();
      do_reset();
      step(1'b1, 1'b1, 4'h0);
      tests_run++;
      if ({y1, y2, y3, valid} !== 4'b1111) begin
         tests_failed++;
         $display("FAIL hold_sample: y=%b%b%b valid=%b, want 111 1", y1, y2, y3, valid);
      end
      step(1'b1, 1'b0, 4'hF);
      tests_run++;
      if ({y1, y2, y3, valid} !== 4'b1110 || seen !== 16'h0001) begin
         tests_failed++;
         $display("FAIL hold: y=%b%b%b valid=%b seen=%h, want 111 0 0001",
                  y1, y2, y3, valid, seen);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'(i));
      tests_run++;
      if (seen !== 16'h00FF) begin
         tests_failed++;
         $display("FAIL mid_pre: seen=%h, want 00ff", seen);
      end
      step(1'b0, 1'b1, 4'h9);
      tests_run++;
      if ({y1, y2, y3, valid, seen, all_seen} !== 21'd0) begin
         tests_failed++;
         $display("FAIL mid_reset: y=%b%b%b valid=%b seen=%h all_seen=%b, want all 0",
                  y1, y2, y3, valid, seen, all_seen);
      end
      // 0011: y1=0 y2=1 y3=1, first edge out of reset must be accepted
      step(1'b1, 1'b1, 4'h3);
      tests_run++;
      if ({y1, y2, y3, valid} !== 4'b0111 || seen !== 16'h0008) begin
         tests_failed++;
         $display("FAIL mid_restart: y=%b%b%b valid=%b seen=%h, want 011 1 0008",
                  y1, y2, y3, valid, seen);
      end
   endtask

   task automatic test_duplicate();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 4'h5);
         tests_run++;
         if (seen !== 16'h0020 || y3 !== 1'b1 || valid !== 1'b1 || all_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL dup[%0d]: seen=%h y3=%b valid=%b all_seen=%b, want 0020 1 1 0",
                     i, seen, y3, valid, all_seen);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0]  exp_y;
      logic [15:0] exp_seen;
      logic [3:0]  v;
      logic        e;
      int          errs;
      errs = 0;
      do_reset();
      exp_y    = 3'b000;
      exp_seen = 16'h0;
      for (int i = 0; i < 1000; i++) begin
         v = 4'($urandom_range(0, 15));
         e = 1'($urandom_range(0, 1));
         step(1'b1, e, v);
         if (e) begin
            exp_y    = ref_tab(v);
            exp_seen = exp_seen | (16'h1 << v);
         end
         tests_run++;
         if ({y1, y2, y3} !== exp_y || valid !== e || seen !== exp_seen
             || all_seen !== (exp_seen == 16'hFFFF)) begin
            tests_failed++;
            if (errs < 10)
               $display("FAIL random[%0d]: y=%b%b%b valid=%b seen=%h, want %b %b %h",
                        i, y1, y2, y3, valid, seen, exp_y, e, exp_seen);
            errs++;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      {a, b, c, d} = 4'h0;
      test_reset();
      test_sweep3();
      test_sweep4();
      test_hold();
      test_reset_mid();
      test_duplicate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tabla1.md
TABLA1 -- requirements
Module: tabla1

Interface
REQ-001 SHALL have no parameters; all truth tables are fixed constants.
REQ-002 SHALL provide `clk`: input, 1 bit, single clock, all state updates on its rising edge.
REQ-003 SHALL provide `rst_n`: input, 1 bit, reset that is synchronous and active-low.
REQ-004 SHALL provide `en`: input, 1 bit, samples the inputs this cycle when high.
REQ-005 SHALL provide `a`, `b`, `c`, `d`: inputs, 1 bit each, table variables; `a` is the MSB.
REQ-006 SHALL provide `y1`: output, 1 bit, registered value of table 1a(a,b,c).
REQ-007 SHALL provide `y2`: output, 1 bit, registered value of table 1b(a,b,c).
REQ-008 SHALL provide `y3`: output, 1 bit, registered value of table 1c(a,b,c,d).
REQ-009 SHALL provide `valid`: output, 1 bit, high when y1..y3 hold a fresh result.
REQ-010 SHALL provide `seen`: output, 16 bits, sticky bitmap of sampled {a,b,c,d} combinations.
REQ-011 SHALL provide `all_seen`: output, 1 bit, high when `seen` equals 16'hFFFF.

Function
REQ-012 Table 1a SHALL be 1 exactly for {a,b,c} minterms 0, 4, 5 (Y = B'C' + AB').
REQ-013 Table 1b SHALL be 1 exactly for {a,b,c} minterms 0, 1, 2, 6, 7 (Y = A'B' + BC' + AB).
REQ-014 Table 1c SHALL be 1 exactly for {a,b,c,d} minterms 0, 2, 3, 4, 5, 7, 8, 12, 13, 15; all other minterms give 0.
REQ-015 Tables 1a and 1b SHALL ignore `d`.
REQ-016 When `en`=1 at a rising edge, y1..y3 SHALL update from that edge's a..d, giving a latency of 1 cycle.
REQ-017 When `en`=1, `valid` SHALL be 1 in the following cycle.
REQ-018 When `en`=0, y1..y3 SHALL hold their previous values and `valid` SHALL be 0 in the following cycle.
REQ-019 When `en`=1, bit {a,b,c,d} of `seen` SHALL be set at that edge; bits SHALL never clear except by reset.
REQ-020 `all_seen` SHALL be combinational from `seen`, with no extra latency.
REQ-021 Repeated sampling of the same combination SHALL be idempotent, with no other state change.
REQ-022 Inputs SHALL be treated as clean 2-state values; there is no X handling.

Reset
REQ-023 While `rst_n`=0 at a rising edge, y1..y3, `valid` and `seen` SHALL all be cleared to 0, and `all_seen` SHALL therefore be 0.
REQ-024 Reset SHALL take priority over `en`; a sample presented with `rst_n`=0 SHALL be discarded.
REQ-025 The first sample SHALL be accepted on the first edge with `rst_n`=1.
REQ-026 Reset asserted mid-sweep SHALL clear `seen`, which then restarts coverage from empty.

Structure
REQ-027 A shared package `tabla1_pkg` SHALL hold the 8-bit constants TABLA1A_TT = 8'b0011_0001 and TABLA1B_TT = 8'b1100_0111.
REQ-028 The same package SHALL hold the 16-bit constant TABLA1C_TT = 16'b1011_0001_1011_1101, where bit i is the output for minterm i.
REQ-029 A single sub-module `tabla1_lut` SHALL be the purely combinational 4-input lookup producing all three table bits from the package constants.
REQ-030 The top level SHALL contain only the registers, the enable and reset muxing, and the coverage bitmap.

Verification
REQ-031 Reset then 3-bit sweep: reset, then `en`=1, d=0, a,b,c counting 000..111 -> y1 = 1,0,0,0,1,1,0,0 and y2 = 1,1,1,0,0,0,1,1, each one cycle after its input.
REQ-032 4-bit sweep: `en`=1, a..d counting 0000..1111 -> y3 = 1,0,1,1,1,1,0,1,1,0,0,0,1,1,0,1 one cycle later, and `all_seen`=1 after the 16th sample.
REQ-033 Hold test: sample 0000 (y1..y3 = 1,1,1), then `en`=0 with inputs 1111 -> outputs stay 1,1,1, `valid`=0, `seen`=16'h0001.
REQ-034 Reset mid-sweep: after 8 samples, assert `rst_n`=0 for 1 cycle with `en`=1 -> all outputs 0, `seen`=0, and that sample is not recorded.
REQ-035 Duplicate sampling: apply 0101 three times -> `seen`=16'h0020, y3=1, `valid` stays 1, `all_seen`=0.
REQ-036 Reference-model check: random a..d with random `en` for 1000 cycles -> y1..y3 match the package truth tables, delayed by 1 cycle.
